code_programmer: RTL

- Writer side of the code-check path: lets an operator reprogram the four 4-bit accept codes that the code checker compares against.
- Entry uses the same switch/button scheme as the checker: 4-bit data switches plus a select push button, acted on at its falling edge.
- Programming is gated by a prog switch and a master code.
- The committed code table is presented on a flat 16-bit bus to the checker.

---
 rtl/code_programmer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/code_programmer.sv
// Writer side of the code-check path: operator reprograms the four 4-bit accept codes behind a master code.
// Optional build macro DUPLICATE_CHECK_EN rejects a code already written earlier in the same session.
module code_programmer #(
  parameter logic [3:0] MASTER = 4'b1111,
  parameter logic [3:0] DEF0   = 4'b0101,
  parameter logic [3:0] DEF1   = 4'b1011,
  parameter logic [3:0] DEF2   = 4'b0001,
  parameter logic [3:0] DEF3   = 4'b1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  data,
  input  logic        select,
  input  logic        prog,
  output logic [15:0] codes,
  output logic [1:0]  slot,
  output logic [2:0]  status,
  output logic        done
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned SLOTS  = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AUTH   = 3'd1,
    S_PROG   = 3'd2,
    S_COMMIT = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t state, next_state;

  logic sel_ff1, sel_ff2, prog_ff1, prog_ff2;
  logic sel_fall, prog_rise, prog_lvl;
  logic dup_hit;
  logic [2:0] status_d;
  logic       done_d;
  logic [SLOTS-1:0][CODE_W-1:0] shadow;

  // Two-flop synchronizers; select idles high so reset cannot fake a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_ff1  <= 1'b1;
      sel_ff2  <= 1'b1;
      prog_ff1 <= 1'b0;
      prog_ff2 <= 1'b0;
    end else begin
      sel_ff1  <= select;
      sel_ff2  <= sel_ff1;
      prog_ff1 <= prog;
      prog_ff2 <= prog_ff1;
    end
  end

  assign sel_fall  = sel_ff2 & ~sel_ff1;
  assign prog_rise = ~prog_ff2 & prog_ff1;
  assign prog_lvl  = prog_ff1;

  always_comb begin
    dup_hit = 1'b0;
`ifdef DUPLICATE_CHECK_EN
    for (int i = 0; i < int'(SLOTS); i++) begin
      if ((2'(i) < slot) && (shadow[i] == data)) dup_hit = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Abort (prog dropped) outranks a same-cycle press
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (prog_rise) next_state = S_AUTH;
      S_AUTH: begin
        if (!prog_lvl)     next_state = S_IDLE;
        else if (sel_fall) next_state = (data == MASTER) ? S_PROG : S_ERROR;
      end
      S_PROG: begin
        if (!prog_lvl)          next_state = S_IDLE;
        else if (sel_fall) begin
          if (dup_hit)          next_state = S_ERROR;
          else if (slot == 2'd3) next_state = S_COMMIT;
        end
      end
      S_COMMIT: next_state = S_IDLE;
      S_ERROR:  if (!prog_lvl) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    status_d = 3'b001;
    done_d   = 1'b0;
    case (next_state)
      S_AUTH, S_PROG: status_d = 3'b010;
      S_COMMIT: begin
        status_d = 3'b010;
        done_d   = 1'b1;
      end
      S_ERROR:  status_d = 3'b100;
      default:  status_d = 3'b001;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= 3'b001;
      done   <= 1'b0;
    end else begin
      status <= status_d;
      done   <= done_d;
    end
  end

  // Working copy in shadow; codes only moves on the cycle after the last slot lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      codes  <= {DEF3, DEF2, DEF1, DEF0};
      shadow <= {DEF3, DEF2, DEF1, DEF0};
      slot   <= 2'd0;
    end else begin
      case (state)
        S_AUTH: begin
          if (!prog_lvl) begin
            slot   <= 2'd0;
            shadow <= codes;
          end else if (sel_fall && (data == MASTER)) begin
            slot <= 2'd0;
          end
        end
        S_PROG: begin
          if (!prog_lvl) begin
            slot   <= 2'd0;
            shadow <= codes;
          end else if (sel_fall && !dup_hit) begin
            shadow[slot] <= data;
            slot         <= slot + 2'd1;
          end
        end
        S_COMMIT: codes <= shadow;
        S_ERROR: begin
          if (!prog_lvl) begin
            slot   <= 2'd0;
            shadow <= codes;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
